// File: rtl/mem_access_unit.sv
// Memory-stage access controller: drives a ready-handshaked data bus from the EX/MEM
// register, steers sub-word byte lanes, extends loads, and stalls the pipeline until acknowledge.
module mem_access_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Valid_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  ResultSrc_M,
    input  logic [1:0]  SizeSrc_M,
    input  logic        LoadSign_M,
    input  logic [31:0] ALUResult_M,
    input  logic [31:0] WriteData_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadData_M,
    output logic        Stall_M,
    output logic        Misaligned_M,
    output logic        Timeout_M
);

    localparam int CW = $clog2(MAX_WAIT + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic          timeout_flag;
    logic [31:0]   read_data;

    logic        is_access;
    logic        is_store;
    logic        is_load;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic [1:0]  lane;
    logic        accept;
    logic        timeout_hit;
    logic        req_int;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    assign lane       = ALUResult_M[1:0];
    assign is_access  = Valid_M && (MemWrite_M || (ResultSrc_M == 2'b01));
    assign is_store   = is_access && MemWrite_M;
    assign is_load    = is_access && !MemWrite_M;
    assign is_byte    = (SizeSrc_M == 2'b10);
    assign is_half    = (SizeSrc_M == 2'b01);
    // Size 2'b11 falls through to the word rules.
    assign misaligned = is_half ? lane[0] : (is_byte ? 1'b0 : (lane != 2'b00));

    assign mem_addr     = {ALUResult_M[31:2], 2'b00};
    assign Misaligned_M = is_access && misaligned;
    assign Timeout_M    = (state == S_DONE) && timeout_flag;
    assign ReadData_M   = read_data;

    always_comb begin
        next_state  = state;
        req_int     = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_access && !misaligned) begin
                    req_int = 1'b1;
                    if (mem_ready) begin
                        accept     = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req_int = 1'b1;
                // An acknowledge on the final wait cycle wins over the timeout.
                if (mem_ready) begin
                    accept     = 1'b1;
                    next_state = S_DONE;
                end else if (wait_cnt == CW'(MAX_WAIT)) begin
                    timeout_hit = 1'b1;
                    next_state  = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Reset must silence the bus and the stall even while a live access sits in EX/MEM.
    assign mem_req = req_int && !rst;
    assign Stall_M = req_int && !rst;
    assign mem_we  = mem_req && MemWrite_M;

    always_comb begin
        mem_wdata = WriteData_M;
        mem_wstrb = 4'b0000;
        if (is_byte) begin
            mem_wdata = {4{WriteData_M[7:0]}};
            mem_wstrb = 4'b0001 << lane;
        end else if (is_half) begin
            mem_wdata = {2{WriteData_M[15:0]}};
            mem_wstrb = 4'b0011 << lane;
        end else begin
            mem_wdata = WriteData_M;
            mem_wstrb = 4'b1111;
        end
        if (!is_store) begin
            mem_wstrb = 4'b0000;
        end
    end

    always_comb begin
        byte_lane = mem_rdata[8*lane +: 8];
        half_lane = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (is_byte) begin
            load_ext = {{24{LoadSign_M && byte_lane[7]}}, byte_lane};
        end else if (is_half) begin
            load_ext = {{16{LoadSign_M && half_lane[15]}}, half_lane};
        end else begin
            load_ext = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
            read_data    <= 32'h0;
        end else begin
            state <= next_state;
            // The counter already reads 1 in the first wait cycle, so it equals MAX_WAIT in the last.
            if (state == S_DONE) begin
                wait_cnt     <= '0;
                timeout_flag <= 1'b0;
            end else begin
                if (next_state == S_WAIT) begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
                if (timeout_hit) begin
                    timeout_flag <= 1'b1;
                end
            end
            if (accept && is_load) begin
                read_data <= load_ext;
            end else if (timeout_hit && is_load) begin
                read_data <= 32'h0;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller sitting directly downstream of the execute stage, behind the EX/MEM pipeline register. It takes the registered address, store data and size/sign controls produced by execute, and drives a ready-handshaked data-memory bus. It performs byte-lane steering for sub-word stores and loads, with sign or zero extension on loads. It stalls the pipeline until the bus acknowledges, and flags misaligned accesses and bus timeouts.

## Interface
**Parameters**
- `MAX_WAIT`, default 255: maximum number of WAIT cycles before a bus access is abandoned.

**Ports**
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `Valid_M` input 1: the EX/MEM register holds a live instruction.
- `MemWrite_M` input 1: the instruction is a store.
- `ResultSrc_M` input 2: the value 2'b01 marks a load.
- `SizeSrc_M` input 2: access size; 00 = word, 01 = half, 10 = byte, 11 is treated as word.
- `LoadSign_M` input 1: 1 = sign-extend the load, 0 = zero-extend.
- `ALUResult_M` input 32: byte address of the access.
- `WriteData_M` input 32: store data, right-aligned.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write enable.
- `mem_addr` output 32: word address, computed as {ALUResult_M[31:2], 2'b00}.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_wstrb` output 4: byte write strobes.
- `mem_ready` input 1: bus acknowledge. For reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 32: read word from the bus.
- `ReadData_M` output 32: extended load result.
- `Stall_M` output 1: holds the PC, IF/ID, ID/EX and EX/MEM registers.
- `Misaligned_M` output 1: the current access is misaligned and has been suppressed.
- `Timeout_M` output 1: one-cycle pulse in DONE when the access was abandoned.

## Operation
**Access detection**
- An access is present when `Valid_M` is high and either `MemWrite_M` is high or `ResultSrc_M` equals 2'b01.

**Misalignment**
- A half access is misaligned when addr[0] = 1.
- A word access is misaligned when addr[1:0] ≠ 00.
- A misaligned access is handled combinationally:
  - `Misaligned_M` = 1.
  - `mem_req` = 0, so no memory write occurs.
  - `Stall_M` = 0.
  - The FSM stays in IDLE and `ReadData_M` is unchanged.

**State machine: IDLE, WAIT, DONE**
- IDLE, with an aligned access present:
  - `mem_req` = 1 and `Stall_M` = 1.
  - If `mem_ready` = 1, capture and go to DONE; otherwise go to WAIT.
- IDLE, with no access present:
  - `mem_req` = 0 and `Stall_M` = 0.
- WAIT:
  - `mem_req` = 1 and `Stall_M` = 1.
  - The wait counter increments every cycle.
  - If `mem_ready` = 1, capture and go to DONE.
  - If the counter equals `MAX_WAIT`, drop `mem_req`, set the timeout flag and go to DONE. `mem_ready` takes priority when both occur in the same cycle.
- DONE:
  - `mem_req` = 0 and `Stall_M` = 0.
  - `Timeout_M` = timeout flag.
  - Next state is always IDLE. The counter and timeout flag clear on this transition.
- Pipeline inputs are stable throughout IDLE→WAIT→DONE because `Stall_M` freezes EX/MEM. The unit does not latch address or store data.

**Store steering** (a = addr[1:0])
- `mem_we` = `MemWrite_M` whenever `mem_req` is high.
- Byte: `mem_wdata` = {4{wd[7:0]}}, `mem_wstrb` = 4'b0001 << a.
- Half: `mem_wdata` = {2{wd[15:0]}}, `mem_wstrb` = 4'b0011 << a.
- Word: `mem_wdata` = wd, `mem_wstrb` = 4'b1111.
- Loads drive `mem_wstrb` = 0.

**Load capture**
- Loads capture on the accepting edge only.
- Byte: select `mem_rdata`[8a+7:8a].
- Half: select `mem_rdata`[16·a[1]+15:16·a[1]].
- The selected lane is extended per `LoadSign_M` and written to the `ReadData_M` register.
- Stores and timeouts capture nothing. `ReadData_M` then holds its last value, except that a timed-out load loads 0.

## Timing
**Reset**
- State = IDLE, counter = 0, timeout flag = 0, `ReadData_M` = 0.
- Consequently `mem_req` = 0 and `Stall_M` = 0 while reset is held.
- Reset asserted mid-access (in WAIT) aborts immediately. A late `mem_ready` after reset is ignored.

**Latency**
- Minimum cost of an aligned access is 1 stall cycle: IDLE with ready → DONE.
- Each extra cycle of `mem_ready` latency adds one stall cycle.
- A timeout costs `MAX_WAIT` + 1 stall cycles.
- `ReadData_M` is valid during DONE and is consumed by MEM/WB at the DONE→IDLE edge.

**Handshake**
- `mem_req`, `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are stable from request assertion until the accepting cycle.
- At most one transaction is outstanding.
- `mem_ready` is ignored while `mem_req` = 0.

**Back-to-back accesses**
- Two consecutive memory instructions are separated by the DONE cycle. The new access is seen in IDLE on the following cycle.

## Test plan
1. **Aligned word load, zero-wait bus.** Load word at 0x100, `mem_rdata` = 0xDEADBEEF, `mem_ready` = 1 immediately. Expect `Stall_M` high for exactly 1 cycle, then `ReadData_M` = 0xDEADBEEF in DONE.
2. **Signed byte load with wait states.** LB at 0x103, `mem_rdata` = 0x80FF_0000, ready after 3 WAIT cycles. Expect 4 stall cycles and `ReadData_M` = 0xFFFFFF80. Repeat with LBU: expect `ReadData_M` = 0x00000080.
3. **Half store at offset 2.** SH at 0x22 with data 0x1234ABCD. Expect `mem_addr` = 0x20, `mem_wstrb` = 4'b1100, `mem_wdata` = 0xABCDABCD, `mem_we` = 1.
4. **Misaligned word store.** SW at 0x41. Expect `Misaligned_M` = 1, `mem_req` = 0, `Stall_M` = 0, FSM stays in IDLE.
5. **Timeout.** `MAX_WAIT` = 4, `mem_ready` held at 0. Expect `mem_req` dropped after 4 WAIT cycles, `Timeout_M` pulse of 1 cycle, `ReadData_M` = 0 for a load. Simultaneous ready on the last WAIT cycle must complete normally with no timeout.
6. **Reset mid-access.** Assert `rst` in the 2nd WAIT cycle. Expect `mem_req` = 0 and `Stall_M` = 0 asynchronously, with `ReadData_M` = 0. After release, an idle bus with no access present raises no stall.
